// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Handshaked ALU. Single-cycle ops (add/sub/logic/shift/rotate)
//                load the output register at the accepting edge; MUL runs a
//                WIDTH-cycle shift-add sequence. Output is held under
//                backpressure. A sticky carry flag (cf) feeds ADC/SBB.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [3:0] C_OP_ADD = 4'd0;
   localparam logic [3:0] C_OP_SUB = 4'd1;
   localparam logic [3:0] C_OP_AND = 4'd2;
   localparam logic [3:0] C_OP_OR  = 4'd3;
   localparam logic [3:0] C_OP_XOR = 4'd4;
   localparam logic [3:0] C_OP_NOT = 4'd5;
   localparam logic [3:0] C_OP_SHL = 4'd6;
   localparam logic [3:0] C_OP_SHR = 4'd7;
   localparam logic [3:0] C_OP_ADC = 4'd8;
   localparam logic [3:0] C_OP_SBB = 4'd9;
   localparam logic [3:0] C_OP_ASR = 4'd10;
   localparam logic [3:0] C_OP_ROL = 4'd11;
   localparam logic [3:0] C_OP_ROR = 4'd12;
   localparam logic [3:0] C_OP_MUL = 4'd13;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 carry_q, carry_d;
   logic                 zero_q, zero_d;
   logic                 negative_q, negative_d;
   logic                 overflow_q, overflow_d;
   logic                 cf_q, cf_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 accept;
   logic                 is_mul;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_sum;
   logic [WIDTH:0]       sum_w;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_v;
   logic                 load_en;
   logic [WIDTH-1:0]     load_res;
   logic                 load_c;
   logic                 load_v;

   assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = (MUL_EN != 0) && (op == C_OP_MUL);
   assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_done = (state_q == ST_MUL_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

   // Single-cycle datapath; MUL and reserved codes fall to the all-zero default
   always_comb begin
      sum_w   = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         C_OP_ADD, C_OP_ADC: begin
            sum_w   = {1'b0, a} + {1'b0, b}
                    + ((op == C_OP_ADC) ? {{WIDTH{1'b0}}, cf_q} : '0);
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         C_OP_SUB, C_OP_SBB: begin
            // Bit WIDTH of the extended difference is the borrow
            sum_w   = {1'b0, a} - {1'b0, b}
                    - ((op == C_OP_SBB) ? {{WIDTH{1'b0}}, cf_q} : '0);
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         C_OP_AND: alu_res = a & b;
         C_OP_OR:  alu_res = a | b;
         C_OP_XOR: alu_res = a ^ b;
         C_OP_NOT: alu_res = ~a;
         C_OP_SHL: begin
            alu_res = {a[WIDTH-2:0], 1'b0};
            alu_c   = a[WIDTH-1];
         end
         C_OP_SHR: begin
            alu_res = {1'b0, a[WIDTH-1:1]};
            alu_c   = a[0];
         end
         C_OP_ASR: begin
            alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
            alu_c   = a[0];
         end
         C_OP_ROL: begin
            alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
            alu_c   = a[WIDTH-1];
         end
         C_OP_ROR: begin
            alu_res = {a[0], a[WIDTH-1:1]};
            alu_c   = a[0];
         end
         default: begin
            alu_res = '0;
         end
      endcase
   end

   // Sequencing: multiply iterations, output-register load and handshake
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      negative_d  = negative_q;
      overflow_d  = overflow_q;
      cf_d        = cf_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      load_en     = 1'b0;
      load_res    = alu_res;
      load_c      = alu_c;
      load_v      = alu_v;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (state_q == ST_MUL_RUN) begin
         acc_d    = mul_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (mul_done) begin
            state_d  = ST_IDLE;
            load_en  = 1'b1;
            load_res = mul_sum[WIDTH-1:0];
            load_c   = |mul_sum[2*WIDTH-1:WIDTH];
            load_v   = 1'b0;
         end
      end else if (accept) begin
         if (is_mul) begin
            state_d  = ST_MUL_RUN;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
         end else begin
            load_en = 1'b1;
         end
      end

      if (load_en) begin
         out_valid_d = 1'b1;
         result_d    = load_res;
         carry_d     = load_c;
         zero_d      = (load_res == '0);
         negative_d  = load_res[WIDTH-1];
         overflow_d  = load_v;
         cf_d        = load_c;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         negative_q  <= 1'b0;
         overflow_q  <= 1'b0;
         cf_q        <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         negative_q  <= negative_d;
         overflow_q  <= overflow_d;
         cf_q        <= cf_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign negative  = negative_q;
   assign overflow  = overflow_q;
   assign busy      = (state_q == ST_MUL_RUN);

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe (WIDTH=8, MUL_EN=1).
//                Directed cases plus random ops against an integer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [3:0] op = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] result;
   logic       carry, zero, negative, overflow, busy;

   int checks = 0;
   int errors = 0;
   int cf_m   = 0;
   int last_res = 0;

   alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Integer reference: results from plain arithmetic on 0..255 values
   task automatic model(input int o, input int x, input int y, input int cin,
                        output int res, output int c, output int v);
      int sx, sy, full, sfull;
      sx = (x >= 128) ? x - 256 : x;
      sy = (y >= 128) ? y - 256 : y;
      res = 0; c = 0; v = 0; full = 0; sfull = 0;
      case (o)
         0, 8: begin
            full  = x + y + ((o == 8) ? cin : 0);
            sfull = sx + sy + ((o == 8) ? cin : 0);
            res = full % 256; c = (full > 255) ? 1 : 0;
            v = (sfull < -128 || sfull > 127) ? 1 : 0;
         end
         1, 9: begin
            full  = x - y - ((o == 9) ? cin : 0);
            sfull = sx - sy - ((o == 9) ? cin : 0);
            res = (full + 256) % 256; c = (full < 0) ? 1 : 0;
            v = (sfull < -128 || sfull > 127) ? 1 : 0;
         end
         2:  res = x & y;
         3:  res = x | y;
         4:  res = x ^ y;
         5:  res = 255 - x;
         6:  begin res = (x * 2) % 256; c = x / 128; end
         7:  begin res = x / 2; c = x % 2; end
         10: begin res = x / 2 + ((x >= 128) ? 128 : 0); c = x % 2; end
         11: begin res = (x * 2) % 256 + x / 128; c = x / 128; end
         12: begin res = x / 2 + (x % 2) * 128; c = x % 2; end
         13: begin full = x * y; res = full % 256; c = (full > 255) ? 1 : 0; end
         default: res = 0;
      endcase
   endtask

   task automatic check_out(input string tag, input int er, input int ec, input int ev);
      check({tag, ".valid"}, {31'b0, out_valid}, 1);
      check({tag, ".result"}, {24'b0, result}, er);
      check({tag, ".carry"}, {31'b0, carry}, ec);
      check({tag, ".zero"}, {31'b0, zero}, (er == 0) ? 1 : 0);
      check({tag, ".neg"}, {31'b0, negative}, (er >= 128) ? 1 : 0);
      check({tag, ".ovf"}, {31'b0, overflow}, ev);
   endtask

   // Issue one op with out_ready high; waits out MUL latency with checks
   task automatic do_op(input string tag, input int o, input int x, input int y);
      int er, ec, ev;
      in_valid = 1'b1; op = 4'(o); a = 8'(x); b = 8'(y); out_ready = 1'b1;
      #1;
      check({tag, ".in_ready"}, {31'b0, in_ready}, 1);
      model(o, x, y, cf_m, er, ec, ev);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (o == 13) begin
         for (int i = 0; i < 8; i++) begin
            check({tag, ".mul_busy"}, {31'b0, busy}, 1);
            check({tag, ".mul_in_ready"}, {31'b0, in_ready}, 0);
            check({tag, ".mul_valid"}, {31'b0, out_valid}, 0);
            @(posedge clk); #1;
         end
         check({tag, ".mul_busy_end"}, {31'b0, busy}, 0);
      end
      check_out(tag, er, ec, ev);
      cf_m = ec;
      last_res = er;
   endtask

   initial begin
      int n;
      // Reset, with a request presented that must be ignored
      in_valid = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      check("rst.valid", {31'b0, out_valid}, 0);
      check("rst.result", {24'b0, result}, 0);
      check("rst.flags", {28'b0, carry, zero, negative, overflow}, 0);
      check("rst.busy", {31'b0, busy}, 0);
      check("rst.in_ready", {31'b0, in_ready}, 1);

      do_op("add_ff_01", 0, 8'hFF, 8'h01);
      do_op("add_7f_01", 0, 8'h7F, 8'h01);
      do_op("add_ff_02", 0, 8'hFF, 8'h02);
      do_op("adc_00_00", 8, 8'h00, 8'h00);
      do_op("sub_03_05", 1, 8'h03, 8'h05);
      do_op("sbb_05_01", 9, 8'h05, 8'h01);
      do_op("ror_01", 12, 8'h01, 8'h00);
      do_op("mul_10_10", 13, 8'h10, 8'h10);
      do_op("rsv_14", 14, 8'hAA, 8'h55);

      // Backpressure: hold the result for 3 cycles, then swap in a new one
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp.drain", {31'b0, out_valid}, 0);
      in_valid = 1'b1; op = 4'd0; a = 8'h12; b = 8'h34; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cf_m = 0;
      for (int i = 0; i < 3; i++) begin
         check("bp.hold_valid", {31'b0, out_valid}, 1);
         check("bp.hold_result", {24'b0, result}, 8'h46);
         check("bp.in_ready", {31'b0, in_ready}, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b1; op = 4'd4; a = 8'hF0; b = 8'hFF; out_ready = 1'b1;
      #1;
      check("bp.release_ready", {31'b0, in_ready}, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp.new_valid", {31'b0, out_valid}, 1);
      check("bp.new_result", {24'b0, result}, 8'h0F);

      // Random ops with occasional stalls and idle gaps
      for (int k = 0; k < 80; k++) begin
         do_op("rand", $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
         n = $urandom_range(0, 2);
         if (n > 0) begin
            out_ready = 1'b0;
            repeat (n) begin
               @(posedge clk); #1;
               check("rand.stall_valid", {31'b0, out_valid}, 1);
               check("rand.stall_result", {24'b0, result}, last_res);
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("rand.gap_valid", {31'b0, out_valid}, 0);
         end
      end

      // Reset 4 cycles into a multiply: result must never appear
      do_op("pre_abort", 0, 8'h7F, 8'h01);
      in_valid = 1'b1; op = 4'd13; a = 8'h0F; b = 8'h0F; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("abort.busy", {31'b0, busy}, 1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cf_m = 0;
      check("abort.valid", {31'b0, out_valid}, 0);
      check("abort.result", {24'b0, result}, 0);
      check("abort.flags", {28'b0, carry, zero, negative, overflow}, 0);
      check("abort.busy_clr", {31'b0, busy}, 0);
      check("abort.in_ready", {31'b0, in_ready}, 1);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("abort.no_valid", {31'b0, out_valid}, 0);
      end
      do_op("adc_after_rst", 8, 8'h00, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 SHALL have parameter MUL_EN, default 1, 1 = op 13 (MUL) implemented, 0 = op 13 treated as reserved.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  4  operation code.
REQ-010 SHALL have port out_valid  output  1  result/flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have ports carry, zero, negative, overflow  output  1 each  registered flags.
REQ-014 SHALL have port busy  output  1  multi-cycle MUL in progress.

Function
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready; a, b, op are sampled at that edge only.
REQ-016 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-017 SHALL implement ops: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A by 1; 7 SHR A by 1 logical; 8 ADC A+B+cf; 9 SBB A-B-cf; 10 ASR A by 1; 11 ROL A; 12 ROR A; 13 MUL (low WIDTH bits of A*B, unsigned); 14-15 reserved.
REQ-018 SHALL set carry: ADD/ADC = carry-out of bit WIDTH-1; SUB/SBB = borrow (1 when unsigned A < B(+cf)); shifts/rotates = bit shifted or rotated out; MUL = 1 if upper WIDTH bits of product nonzero; all others 0.
REQ-019 SHALL set overflow = signed two's-complement overflow for ADD/ADC/SUB/SBB, 0 for all other ops.
REQ-020 SHALL set zero = (result==0) and negative = result[WIDTH-1] for every op.
REQ-021 SHALL produce, for reserved ops (and op 13 when MUL_EN=0), result 0, zero 1, all other flags 0, latency 1.
REQ-022 SHALL hold an internal carry flag cf, updated with the carry output at the edge each result is loaded into the output register; ADC/SBB use cf as it stood before that edge.
REQ-023 SHALL, for single-cycle ops, load result/flags and set out_valid at the accepting edge (out_valid visible the following cycle).
REQ-024 SHALL implement MUL with states IDLE -> MUL_RUN (WIDTH shift-add iterations, one per cycle) -> IDLE, loading result and setting out_valid on the WIDTH-th edge after acceptance; busy = 1 while in MUL_RUN.
REQ-025 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL clear out_valid on an edge where out_valid && out_ready unless a new result is loaded on that same edge, in which case out_valid stays 1 and the new result replaces the old (back-to-back throughput of one op per cycle).
REQ-027 SHALL, when WIDTH-bit arithmetic wraps, return the low WIDTH bits with the carry/borrow reported via carry only.

Reset
REQ-028 SHALL, on any edge with rst=1, set state IDLE, out_valid 0, result 0, carry/zero/negative/overflow 0, cf 0, busy 0, regardless of in-flight activity.
REQ-029 SHALL, when rst asserts during MUL_RUN, abort the multiply with no result ever presented.
REQ-030 SHALL ignore in_valid on edges where rst=1; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (WIDTH=8, MUL_EN=1)
REQ-031 SHALL test ADD 0xFF+0x01 -> result 0x00, carry 1, zero 1, overflow 0, out_valid 1 cycle after accept.
REQ-032 SHALL test ADD 0x7F+0x01 -> 0x80, overflow 1, negative 1, carry 0; then ADD 0xFF+0x02 -> 0x01, carry 1, followed by ADC 0x00+0x00 -> 0x01, carry 0.
REQ-033 SHALL test SUB 0x03-0x05 -> 0xFE, carry 1, negative 1; then SBB 0x05-0x01 -> 0x03; ROR 0x01 -> 0x80, carry 1.
REQ-034 SHALL test MUL 0x10*0x10 -> result 0x00, carry 1, zero 1; out_valid 8 cycles after accept; in_ready 0 and busy 1 throughout.
REQ-035 SHALL test backpressure: out_ready held 0 for 3 cycles -> result stable, in_ready 0; out_ready 1 plus new request on the same edge -> new result loaded, out_valid stays 1.
REQ-036 SHALL test rst asserted 4 cycles into MUL 0x0F*0x0F -> out_valid never rises, all outputs 0, in_ready 1 the cycle after rst deasserts.
